gpio_apb_bank: RTL

APB responder holding one bank of GPIO registers: direction, output, synchronized input, and edge-triggered interrupt logic. It sits on the APB side of the SPI-to-APB bridge, one instance per `b_psel` bit. The bridge is the APB initiator and this block completes its transfers. All register state is visible to the SPI host through the bridge.

---
 rtl/gpio_apb_bank_if.sv | 25 ++
 rtl/gpio_apb_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_apb_bank_if.sv
// APB bus bundle between the SPI-to-APB bridge (master) and one GPIO bank
// (slave). Pins, clock and reset are carried as plain module ports.
interface gpio_apb_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/gpio_apb_bank.sv
// gpio_apb_bank: APB responder for one bank of GPIO pins.
// Registers: 0 DIR, 1 OUT, 2 IN (read-only), 3 IRQ_EN, 4 IRQ_STAT (W1C),
// 5 IRQ_POL (1 = rising, 0 = falling); 6 and 7 reserved (error response).
// Optional build macro: GPIO_BANK_WAIT_EN inserts one wait cycle per access
// and captures read data at the end of that wait cycle.
module gpio_apb_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  gpio_apb_bank_if.slave        apb,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [DATA_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH-1:0] A_DIR  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_OUT  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_IN   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_IEN  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_POL  = ADDR_WIDTH'(5);

  typedef enum logic [1:0] {
`ifdef GPIO_BANK_WAIT_EN
    ST_WAIT   = 2'd2,
`endif
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1
  } state_t;

  state_t state_q, state_d;

  // Transfer context latched in the setup cycle
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  // Register file
  logic [DATA_WIDTH-1:0] dir_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] ien_q;
  logic [DATA_WIDTH-1:0] pol_q;
  logic [DATA_WIDTH-1:0] stat_q, stat_d;
  logic                  irq_q;

  // Input synchronizer (s1, s2) and edge history (s3)
  logic [DATA_WIDTH-1:0] s1_q, s2_q, s3_q;

  logic [DATA_WIDTH-1:0] edge_set;
  logic [DATA_WIDTH-1:0] w1c_mask;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  setup;
  logic                  setup_err;
  logic                  pready_c;
  logic                  commit;

  assign setup = apb.psel & ~apb.penable;

  // Reserved slots always error; IN is read-only so a write to it errors too
  assign setup_err = (apb.paddr > A_POL) || (apb.pwrite && (apb.paddr == A_IN));

  // Read mux: in IDLE the live bus address is used (capture at setup),
  // otherwise the latched address (capture at the end of the wait cycle)
  always_comb begin
    rd_addr = (state_q == ST_IDLE) ? apb.paddr : addr_q;
    rd_val  = '0;
    case (rd_addr)
      A_DIR:   rd_val = dir_q;
      A_OUT:   rd_val = out_q;
      A_IN:    rd_val = s2_q;
      A_IEN:   rd_val = ien_q;
      A_STAT:  rd_val = stat_q;
      A_POL:   rd_val = pol_q;
      default: rd_val = '0;
    endcase
  end

  // APB transfer FSM: next state, transfer context and commit strobe
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    pready_c = 1'b0;
    commit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          addr_d  = apb.paddr;
          write_d = apb.pwrite;
          err_d   = setup_err;
`ifdef GPIO_BANK_WAIT_EN
          state_d = ST_WAIT;
`else
          prdata_d = rd_val;
          state_d  = ST_ACCESS;
`endif
        end
      end
`ifdef GPIO_BANK_WAIT_EN
      ST_WAIT: begin
        if (!apb.psel) begin
          state_d = ST_IDLE;
        end else begin
          prdata_d = rd_val;
          state_d  = ST_ACCESS;
        end
      end
`endif
      ST_ACCESS: begin
        if (!apb.psel) begin
          state_d = ST_IDLE;
        end else begin
          pready_c = 1'b1;
          commit   = write_q & ~err_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and transfer context registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
    end
  end

  // Per-pin edge detect; IRQ_POL picks which edge sets the status bit
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_edge
      assign edge_set[gi] = pol_q[gi] ? ( s2_q[gi] & ~s3_q[gi])
                                      : (~s2_q[gi] &  s3_q[gi]);
    end
  endgenerate

  // Status update: a same-cycle edge set overrides the W1C clear
  always_comb begin
    w1c_mask = (commit && (addr_q == A_STAT)) ? apb.pwdata : '0;
    stat_d   = (stat_q & ~w1c_mask) | edge_set;
  end

  // Pin synchronizer and edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= gpio_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Register writes commit at the end of the pready cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q  <= '0;
      out_q  <= '0;
      ien_q  <= '0;
      pol_q  <= '0;
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
      if (commit) begin
        case (addr_q)
          A_DIR:   dir_q <= apb.pwdata;
          A_OUT:   out_q <= apb.pwdata;
          A_IEN:   ien_q <= apb.pwdata;
          A_POL:   pol_q <= apb.pwdata;
          default: ;
        endcase
      end
    end
  end

  // Level interrupt, one cycle behind status/enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(stat_q & ien_q);
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_c;
  assign apb.pslverr = pready_c & err_q;
  assign gpio_oe     = dir_q;
  assign gpio_out    = out_q & dir_q;
  assign irq         = irq_q;

endmodule
